// File: rtl/arith_issue_queue.sv
// -----------------------------------------------------------------------------
// arith_issue_queue
//
// Purpose: a small in-order FIFO that buffers arithmetic requests from an
// upstream producer and issues them, one per cycle, to a downstream
// arithmetic unit through a registered operand stage. Operands and op code
// are passed through bit-exact; no arithmetic happens here.
//
// Parameters:
//   WIDTH  operand width (default 16)
//   DEPTH  number of queue entries, power of two, >= 2 (default 4)
//
// Ports:
//   clk          in   single clock, all state on rising edge
//   reset        in   asynchronous, active-low reset
//   in_valid     in   upstream request present
//   in_ready     out  queue can accept a request this cycle (count < DEPTH)
//   in_data_1    in   first operand of request
//   in_data_2    in   second operand of request
//   in_op_sel    in   operation code of request
//   issue_stall  in   downstream unit cannot take a new operation
//   data_1       out  registered first operand to arithmetic unit
//   data_2       out  registered second operand to arithmetic unit
//   op_sel       out  registered operation code to arithmetic unit
//   issue_valid  out  data_1/data_2/op_sel hold a newly issued operation
//   issued_count out  (only with ARITH_ISSUE_CNT_EN) 16-bit wrapping pop count
//   count        out  current number of queued entries
//
// Optional feature macro: ARITH_ISSUE_CNT_EN adds the issued_count output.
// -----------------------------------------------------------------------------
module arith_issue_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data_1,
  input  logic [WIDTH-1:0]         in_data_2,
  input  logic [1:0]               in_op_sel,
  input  logic                     issue_stall,
  output logic [WIDTH-1:0]         data_1,
  output logic [WIDTH-1:0]         data_2,
  output logic [1:0]               op_sel,
  output logic                     issue_valid,
`ifdef ARITH_ISSUE_CNT_EN
  output logic [15:0]              issued_count,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem1  [DEPTH];
  logic [WIDTH-1:0] r_mem2  [DEPTH];
  logic [1:0]       r_memOp [DEPTH];

  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] r_data1;
  logic [WIDTH-1:0] r_data2;
  logic [1:0]       r_opSel;
  logic             r_issueValid;

  logic             w_push;
  logic             w_pop;

  // Ready depends only on the registered occupancy so it never forms a
  // combinational path from in_valid or issue_stall.
  assign in_ready = (r_count < DEPTH_C);
  assign w_push   = in_valid & in_ready;
  // A pop needs something to pop; with an empty queue the stall is moot.
  assign w_pop    = (r_count != '0) & ~issue_stall;

  assign data_1      = r_data1;
  assign data_2      = r_data2;
  assign op_sel      = r_opSel;
  assign issue_valid = r_issueValid;
  assign count       = r_count;

  // Entry storage is left unreset; pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem1[r_wrPtr]  <= in_data_1;
      r_mem2[r_wrPtr]  <= in_data_2;
      r_memOp[r_wrPtr] <= in_op_sel;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
  // push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue stage: the head entry is captured on a pop and held otherwise, so
  // the downstream unit always sees the last issued operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data1      <= '0;
      r_data2      <= '0;
      r_opSel      <= '0;
      r_issueValid <= 1'b0;
    end else begin
      r_issueValid <= w_pop;
      if (w_pop) begin
        r_data1 <= r_mem1[r_rdPtr];
        r_data2 <= r_mem2[r_rdPtr];
        r_opSel <= r_memOp[r_rdPtr];
      end
    end
  end

`ifdef ARITH_ISSUE_CNT_EN
  logic [15:0] r_issuedCount;

  assign issued_count = r_issuedCount;

  // Free-running pop counter; wraps from 65535 back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_issuedCount <= '0;
    end else if (w_pop) begin
      r_issuedCount <= r_issuedCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arith_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_arith_issue_queue
//
// Self-checking bench for arith_issue_queue. A queue-based reference model
// tracks what must be issued; a compare process checks every cycle, and
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_arith_issue_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data_1 = '0;
  logic [WIDTH-1:0]  in_data_2 = '0;
  logic [1:0]        in_op_sel = '0;
  logic              issue_stall = 1'b0;
  logic [WIDTH-1:0]  data_1;
  logic [WIDTH-1:0]  data_2;
  logic [1:0]        op_sel;
  logic              issue_valid;
  logic [$clog2(DEPTH):0] count;
`ifdef ARITH_ISSUE_CNT_EN
  logic [15:0]       issued_count;
`endif

  arith_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data_1   (in_data_1),
    .in_data_2   (in_data_2),
    .in_op_sel   (in_op_sel),
    .issue_stall (issue_stall),
    .data_1      (data_1),
    .data_2      (data_2),
    .op_sel      (op_sel),
    .issue_valid (issue_valid),
`ifdef ARITH_ISSUE_CNT_EN
    .issued_count(issued_count),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic checkEn = 1'b0;

  // One comparison: counts it, reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs from a falling edge, then wait for the next one.
  task automatic applyStimulus(input logic v, input logic [15:0] d1, input logic [15:0] d2,
                               input logic [1:0] op, input logic stall);
    in_valid    = v;
    in_data_1   = d1;
    in_data_2   = d2;
    in_op_sel   = op;
    issue_stall = stall;
    @(negedge clk);
  endtask

  // Reference model: an ordered list of queued requests plus the last issue.
  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [1:0]  op;
  } entry_t;

  entry_t      modelQ[$];
  logic        expValid = 1'b0;
  entry_t      expOut = '0;
  logic [15:0] expIssued = '0;

  always @(posedge clk or negedge reset) begin
    bit doPush;
    bit doPop;
    if (!reset) begin
      modelQ.delete();
      expValid  = 1'b0;
      expOut    = '0;
      expIssued = '0;
    end else begin
      doPush = in_valid && (modelQ.size() < DEPTH);
      doPop  = (modelQ.size() > 0) && !issue_stall;
      expValid = doPop;
      if (doPop) begin
        expOut = modelQ.pop_front();
        expIssued = expIssued + 16'd1;
      end
      if (doPush) modelQ.push_back('{d1: in_data_1, d2: in_data_2, op: in_op_sel});
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_issue_valid", 32'(issue_valid), 32'(expValid));
      checkOutput("cyc_count", 32'(count), 32'(modelQ.size()));
      checkOutput("cyc_in_ready", 32'(in_ready), 32'(modelQ.size() < DEPTH));
      checkOutput("cyc_data_1", 32'(data_1), 32'(expOut.d1));
      checkOutput("cyc_data_2", 32'(data_2), 32'(expOut.d2));
      checkOutput("cyc_op_sel", 32'(op_sel), 32'(expOut.op));
`ifdef ARITH_ISSUE_CNT_EN
      checkOutput("cyc_issued_count", 32'(issued_count), 32'(expIssued));
`endif
    end
  end

  // Record every issued first operand just after the edge that issued it.
  logic [15:0] issueLog[$];
  always @(posedge clk) begin
    #1;
    if (issue_valid) issueLog.push_back(data_1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_data_1", 32'(data_1), 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);

    // Single request, one-edge issue latency
    $display("[TB] single request latency");
    applyStimulus(1'b1, 16'd3, 16'd7, 2'b01, 1'b0);
    checkOutput("lat_count_after_push", 32'(count), 32'd1);
    checkOutput("lat_valid_after_push", 32'(issue_valid), 32'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 1'b0);
    checkOutput("lat_issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("lat_data_1", 32'(data_1), 32'd3);
    checkOutput("lat_data_2", 32'(data_2), 32'd7);
    checkOutput("lat_op_sel", 32'(op_sel), 32'd1);
    checkOutput("lat_count_end", 32'(count), 32'd0);
    applyStimulus(1'b0, 16'd0, 16'd0, 2'b00, 1'b0);
    checkOutput("lat_valid_drop", 32'(issue_valid), 32'd0);
    checkOutput("lat_data_hold", 32'(data_1), 32'd3);

    // Fill under stall, fifth request held, then drain in order
    $display("[TB] stall fill and drain");
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 16'(i), 16'(i + 100), 2'(i), 1'b1);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'd5, 16'd105, 2'd1, 1'b1);
    checkOutput("full_count_held", 32'(count), 32'd4);
    checkOutput("full_no_issue", 32'(issue_valid), 32'd0);
    issueLog.delete();
    applyStimulus(1'b1, 16'd5, 16'd105, 2'd1, 1'b0);
    checkOutput("full_pop_count", 32'(count), 32'd3);
    checkOutput("full_ready_back", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'd5, 16'd105, 2'd1, 1'b0);
    checkOutput("full_pushpop_count", 32'(count), 32'd3);
    repeat (3) applyStimulus(1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
    checkOutput("drain_len", 32'(issueLog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < issueLog.size()) checkOutput("drain_order", 32'(issueLog[i]), 32'(i + 1));

    // Simultaneous push and pop with two entries queued
    $display("[TB] push and pop on same edge");
    applyStimulus(1'b1, 16'd20, 16'd0, 2'd2, 1'b1);
    applyStimulus(1'b1, 16'd21, 16'd0, 2'd3, 1'b1);
    checkOutput("pp_count_before", 32'(count), 32'd2);
    issueLog.delete();
    applyStimulus(1'b1, 16'd22, 16'd0, 2'd0, 1'b0);
    checkOutput("pp_count_same", 32'(count), 32'd2);
    checkOutput("pp_data_1", 32'(data_1), 32'd20);
    repeat (3) applyStimulus(1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
    checkOutput("pp_len", 32'(issueLog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < issueLog.size()) checkOutput("pp_order", 32'(issueLog[i]), 32'(20 + i));

    // Nine requests streaming through, wrapping the pointers twice
    $display("[TB] wrap-around stream");
    issueLog.delete();
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 16'(40 + i), 16'(16'hA000 + i), 2'(i), 1'b0);
    repeat (2) applyStimulus(1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
    checkOutput("wrap_len", 32'(issueLog.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < issueLog.size()) checkOutput("wrap_order", 32'(issueLog[i]), 32'(40 + i));

    // Asynchronous reset with three entries queued
    $display("[TB] async reset mid-operation");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'(60 + i), 16'd9, 2'd3, 1'b1);
    checkOutput("ar_count_before", 32'(count), 32'd3);
    in_valid = 1'b0;
    issue_stall = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("ar_count", 32'(count), 32'd0);
    checkOutput("ar_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("ar_data_1", 32'(data_1), 32'd0);
    checkOutput("ar_data_2", 32'(data_2), 32'd0);
    checkOutput("ar_op_sel", 32'(op_sel), 32'd0);
    checkOutput("ar_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    issueLog.delete();
    repeat (3) applyStimulus(1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
    checkOutput("ar_no_stale", 32'(issueLog.size()), 32'd0);
    checkOutput("ar_ready_after", 32'(in_ready), 32'd1);

`ifdef ARITH_ISSUE_CNT_EN
    // Issue counter
    $display("[TB] issued counter");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 16'(i), 16'(i), 2'(i), 1'b0);
    repeat (2) applyStimulus(1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
    checkOutput("cnt_six", 32'(issued_count), 32'd6);
    #2 reset = 1'b0;
    #1;
    checkOutput("cnt_reset", 32'(issued_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_issue_queue.md
ARITH_ISSUE_QUEUE -- requirements
Module: arith_issue_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width.
REQ-002 The block SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 Port in_valid  input  1  upstream request present.
REQ-006 Port in_ready  output  1  queue can accept a request this cycle.
REQ-007 Port in_data_1  input  WIDTH  first operand of request.
REQ-008 Port in_data_2  input  WIDTH  second operand of request.
REQ-009 Port in_op_sel  input  2  operation code of request.
REQ-010 Port issue_stall  input  1  downstream arithmetic unit cannot take a new operation.
REQ-011 Port data_1  output  WIDTH  registered first operand to arithmetic unit.
REQ-012 Port data_2  output  WIDTH  registered second operand to arithmetic unit.
REQ-013 Port op_sel  output  2  registered operation code to arithmetic unit.
REQ-014 Port issue_valid  output  1  data_1/data_2/op_sel hold a newly issued operation this cycle.
REQ-015 Port count  output  $clog2(DEPTH)+1  current number of queued entries.

Function
REQ-016 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; the entry {in_data_1, in_data_2, in_op_sel} is written at the tail.
REQ-017 in_ready SHALL equal (count < DEPTH), derived from registered state only, with no combinational dependence on in_valid or issue_stall.
REQ-018 Pop SHALL occur on a rising edge where count > 0 and issue_stall=0; the head entry is registered into data_1/data_2/op_sel and issue_valid is 1 for the following cycle.
REQ-019 issue_valid SHALL be 0 after any edge without a pop; data_1/data_2/op_sel SHALL then hold their last issued values unchanged.
REQ-020 Latency SHALL be: request pushed into an empty queue at edge N, issue_valid=1 and operands valid after edge N+1 (given issue_stall=0).
REQ-021 Entries SHALL issue in strict push order; read/write pointers wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and both operations SHALL take effect.
REQ-023 When full (count=DEPTH), in_ready=0 and in_valid is ignored; a pop in that cycle makes in_ready=1 the next cycle.
REQ-024 When empty, issue_stall has no effect and issue_valid stays 0.
REQ-025 issue_stall=1 SHALL block pops only; pushes continue until full.
REQ-026 The block SHALL perform no arithmetic on operands; all fields pass through bit-exact.

Reset
REQ-027 On reset=0, immediately and independent of clk: count=0, pointers=0, data_1=0, data_2=0, op_sel=0, issue_valid=0, in_ready=1 once pointers clear.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; no entry queued before reset issues after it.
REQ-029 Queue storage contents need not be reset.

Configuration
REQ-030 Macro ARITH_ISSUE_CNT_EN SHALL, when defined, add output issued_count (16 bits) incrementing by 1 on each pop, wrapping 65535->0, reset to 0.
REQ-031 Without ARITH_ISSUE_CNT_EN the port issued_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset then push {3,7,op 01} with issue_stall=0 -> issue_valid=1 exactly one edge later with data_1=3, data_2=7, op_sel=01; count returns to 0.
REQ-033 issue_stall=1, push 5 requests {1..5} -> in_ready=0 after 4th push, count=4, 5th held by upstream; release stall -> issues 1,2,3,4,5 in order on consecutive cycles.
REQ-034 Count=2, push and pop on same edge -> count stays 2, issue order preserved.
REQ-035 Push 9 requests through queue with no stall -> pointer wrap-around, all 9 issued in order, no duplicates or drops.
REQ-036 Count=3, drive reset=0 between clock edges -> outputs zero immediately, issue_valid=0; after release no stale entry issues, in_ready=1.
REQ-037 With ARITH_ISSUE_CNT_EN defined, issue 6 operations -> issued_count=6; reset -> 0.
